// File: rtl/proc_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, redirect from control and the F->D handoff.
// master = fetch unit, slave = the surrounding memory/control environment.
interface proc_fetch_unit_if;
  logic        imemreq_val;
  logic        imemreq_rdy;
  logic [31:0] imemreq_addr;
  logic        imemresp_val;
  logic [31:0] imemresp_data;
  logic        redirect_val;
  logic [31:0] redirect_target;
  logic        f2d_val;
  logic [31:0] f2d_inst;
  logic [31:0] f2d_pc;
  logic        d_rdy;

  modport master (
    output imemreq_val, imemreq_addr, f2d_val, f2d_inst, f2d_pc,
    input  imemreq_rdy, imemresp_val, imemresp_data, redirect_val, redirect_target, d_rdy
  );

  modport slave (
    input  imemreq_val, imemreq_addr, f2d_val, f2d_inst, f2d_pc,
    output imemreq_rdy, imemresp_val, imemresp_data, redirect_val, redirect_target, d_rdy
  );
endinterface

// File: rtl/proc_fetch_unit.sv
// TinyRV1 fetch stage: credit-limited in-order imem requests, instruction queue, tagless redirect squash.
// Defining FETCH_PERF_EN adds saturating perf_fetched / perf_dropped / perf_starve counters.
module proc_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          QDEPTH   = 2,
  parameter int          MAX_OUT  = 4
) (
  input  logic              clk,
  input  logic              rst,
  proc_fetch_unit_if.master bus
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_fetched,
  output logic [31:0]       perf_dropped,
  output logic [31:0]       perf_starve
`endif
);

  localparam int CW = $clog2(MAX_OUT + QDEPTH + 1);
  localparam int PW = $clog2(QDEPTH);
  localparam logic [CW-1:0] QDEPTH_C  = CW'(QDEPTH);
  localparam logic [CW-1:0] MAX_OUT_C = CW'(MAX_OUT);
  localparam logic [CW-1:0] ONE_C     = CW'(1);
  localparam logic [CW-1:0] ZERO_C    = CW'(0);
  localparam logic [PW-1:0] PONE_C    = PW'(1);
  localparam logic [31:0]   NOP       = 32'h0000_0013;

  typedef enum logic [0:0] {INIT = 1'b0, RUN = 1'b1} state_t;

  state_t        state_r, state_next_s;
  logic [31:0]   fetch_pc_r, fetch_pc_next_s;
  logic [31:0]   deq_pc_r, deq_pc_next_s;
  logic [CW-1:0] outstanding_r, outstanding_next_s;
  logic [CW-1:0] drop_cnt_r, drop_next_s;
  logic [CW-1:0] count_r, count_next_s;
  logic [PW-1:0] head_r, head_next_s, tail_r, tail_next_s;
  logic [31:0]   mem_r [QDEPTH];
  logic          req_val_r, req_val_next_s, f2d_val_r;
  logic          req_fire_s, deq_s, enq_s, drop_s;
  logic [31:0]   target_s;

  assign req_fire_s = req_val_r & bus.imemreq_rdy;
  assign deq_s      = f2d_val_r & bus.d_rdy;
  assign drop_s     = bus.imemresp_val & (bus.redirect_val | (drop_cnt_r != ZERO_C));
  assign enq_s      = bus.imemresp_val & ~drop_s;
  assign target_s   = bus.redirect_target & 32'hFFFF_FFFC;

  assign bus.imemreq_val  = req_val_r;
  assign bus.imemreq_addr = fetch_pc_r;
  assign bus.f2d_val      = f2d_val_r;
  assign bus.f2d_inst     = mem_r[head_r];
  assign bus.f2d_pc       = deq_pc_r;

  // Next-state: FSM, counters, pointers, and the request/valid flags registered one cycle ahead
  always_comb begin
    state_next_s       = state_r;
    fetch_pc_next_s    = fetch_pc_r;
    deq_pc_next_s      = deq_pc_r;
    drop_next_s        = drop_cnt_r;
    count_next_s       = count_r;
    head_next_s        = head_r;
    tail_next_s        = tail_r;
    outstanding_next_s = outstanding_r;
    req_val_next_s     = 1'b0;

    case (state_r)
      INIT:    state_next_s = RUN;
      RUN:     state_next_s = RUN;
      default: state_next_s = INIT;
    endcase

    outstanding_next_s = outstanding_r + (req_fire_s ? ONE_C : ZERO_C)
                                       - (bus.imemresp_val ? ONE_C : ZERO_C);

    // A redirect turns every in-flight request (including one firing now) into a stale one
    if (bus.redirect_val) begin
      fetch_pc_next_s = target_s;
      deq_pc_next_s   = target_s;
      drop_next_s     = outstanding_next_s;
      count_next_s    = ZERO_C;
      head_next_s     = tail_r;
    end else begin
      fetch_pc_next_s = req_fire_s ? fetch_pc_r + 32'd4 : fetch_pc_r;
      deq_pc_next_s   = deq_s ? deq_pc_r + 32'd4 : deq_pc_r;
      drop_next_s     = (bus.imemresp_val && (drop_cnt_r != ZERO_C)) ? drop_cnt_r - ONE_C : drop_cnt_r;
      count_next_s    = count_r + (enq_s ? ONE_C : ZERO_C) - (deq_s ? ONE_C : ZERO_C);
      head_next_s     = deq_s ? head_r + PONE_C : head_r;
    end

    tail_next_s    = enq_s ? tail_r + PONE_C : tail_r;
    req_val_next_s = (state_next_s == RUN) && (outstanding_next_s < MAX_OUT_C) &&
                     (((outstanding_next_s - drop_next_s) + count_next_s) < QDEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= INIT;
      fetch_pc_r    <= RESET_PC;
      deq_pc_r      <= RESET_PC;
      outstanding_r <= ZERO_C;
      drop_cnt_r    <= ZERO_C;
      count_r       <= ZERO_C;
      head_r        <= '0;
      tail_r        <= '0;
      req_val_r     <= 1'b0;
      f2d_val_r     <= 1'b0;
    end else begin
      state_r       <= state_next_s;
      fetch_pc_r    <= fetch_pc_next_s;
      deq_pc_r      <= deq_pc_next_s;
      outstanding_r <= outstanding_next_s;
      drop_cnt_r    <= drop_next_s;
      count_r       <= count_next_s;
      head_r        <= head_next_s;
      tail_r        <= tail_next_s;
      req_val_r     <= req_val_next_s;
      f2d_val_r     <= (count_next_s != ZERO_C);
    end
  end

  // Queue storage resets to nops so the idle head presents a harmless instruction
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < QDEPTH; i++) mem_r[i] <= NOP;
    end else if (enq_s) begin
      mem_r[tail_r] <= bus.imemresp_data;
    end
  end

`ifdef FETCH_PERF_EN
  function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  logic [31:0] flushed_s;

  always_comb begin
    flushed_s = 32'd0;
    if (bus.redirect_val) begin
      flushed_s = 32'(count_r - (deq_s ? ONE_C : ZERO_C));
    end else begin
      flushed_s = 32'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      perf_fetched <= 32'd0;
      perf_dropped <= 32'd0;
      perf_starve  <= 32'd0;
    end else begin
      perf_fetched <= sat_add(perf_fetched, {31'd0, deq_s});
      perf_dropped <= sat_add(perf_dropped, flushed_s + {31'd0, drop_s});
      perf_starve  <= sat_add(perf_starve, {31'd0, bus.d_rdy & ~f2d_val_r});
    end
  end
`endif

endmodule

// File: tb/tb_proc_fetch_unit.sv
// Randomized bench for proc_fetch_unit: a queue-based model of in-flight requests (live/stale)
// and buffered instructions predicts every output each cycle; the memory is an in-order latency queue.
module tb_proc_fetch_unit;
  localparam logic [31:0] RPC = 32'h0000_0200;
  localparam int          QD  = 2;
  localparam int          MO  = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  proc_fetch_unit_if bus();

  proc_fetch_unit #(.RESET_PC(RPC), .QDEPTH(QD), .MAX_OUT(MO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct packed { logic stale; logic [31:0] addr; } infl_t;
  typedef struct packed { logic [31:0] data; int due; } mresp_t;

  infl_t       infl_q[$];
  logic [31:0] buf_q[$];
  mresp_t      mem_q[$];
  logic [31:0] m_fetch, m_deq;
  bit          m_run, m_ok, just_reset;
  int          cyc, lat_lo, lat_hi;
  int          total, bad;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  function automatic int live_cnt();
    int n = 0;
    foreach (infl_q[i]) if (!infl_q[i].stale) n++;
    return n;
  endfunction

  function automatic bit exp_req_val();
    return m_run && (infl_q.size() < MO) && ((live_cnt() + buf_q.size()) < QD);
  endfunction

  task automatic check_outputs();
    chk("req_val", {31'd0, bus.imemreq_val}, {31'd0, exp_req_val()});
    chk("req_addr", bus.imemreq_addr, m_fetch);
    chk("f2d_val", {31'd0, bus.f2d_val}, {31'd0, buf_q.size() > 0});
    if (buf_q.size() > 0) begin
      chk("f2d_pc", bus.f2d_pc, buf_q[0]);
      chk("f2d_inst", bus.f2d_inst, mem_word(buf_q[0]));
    end else begin
      chk("f2d_pc_idle", bus.f2d_pc, m_deq);
    end
    if (just_reset) chk("reset_nop", bus.f2d_inst, NOP);
  endtask

  // One clock: check outputs, drive inputs, advance the model to the post-edge state
  task automatic step(input logic r, input logic rdy, input logic drdy,
                      input logic rv, input logic [31:0] tgt);
    bit          fire, deq, rsp;
    logic [31:0] rdata;
    infl_t       f;
    @(negedge clk);
    if (m_ok) check_outputs();
    just_reset = 0;
    rst = r;
    bus.imemreq_rdy     = rdy;
    bus.d_rdy           = drdy;
    bus.redirect_val    = rv;
    bus.redirect_target = tgt;
    rsp   = 0;
    rdata = $urandom();
    if (r && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      rsp   = 1;
      rdata = mem_q[0].data;
      void'(mem_q.pop_front());
    end
    bus.imemresp_val  = rsp;
    bus.imemresp_data = rdata;
    if (!r) begin
      mem_q.delete(); infl_q.delete(); buf_q.delete();
      m_fetch = RPC; m_deq = RPC; m_run = 0; m_ok = 1; just_reset = 1;
    end else begin
      fire = exp_req_val() && rdy;
      deq  = (buf_q.size() > 0) && drdy;
      if (deq) begin
        void'(buf_q.pop_front());
        m_deq += 32'd4;
      end
      if (rsp && infl_q.size() > 0) begin
        f = infl_q.pop_front();
        if (!f.stale && !rv) buf_q.push_back(f.addr);
      end
      if (fire) begin
        mem_q.push_back('{data: mem_word(m_fetch), due: cyc + int'($urandom_range(lat_hi, lat_lo))});
        infl_q.push_back('{stale: rv, addr: m_fetch});
        m_fetch += 32'd4;
      end
      if (rv) begin
        buf_q.delete();
        foreach (infl_q[i]) infl_q[i].stale = 1'b1;
        m_fetch = {tgt[31:2], 2'b00};
        m_deq   = {tgt[31:2], 2'b00};
      end
      m_run = 1;
    end
    cyc++;
  endtask

  task automatic run_plain(input int n, input logic drdy);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, drdy, 1'b0, 32'd0);
  endtask

  initial begin
    int n;
    total = 0; bad = 0; cyc = 0; m_ok = 0; m_run = 0; just_reset = 0;
    lat_lo = 1; lat_hi = 1;
    bus.imemreq_rdy = 1'b0; bus.d_rdy = 1'b0; bus.redirect_val = 1'b0;
    bus.redirect_target = 32'd0; bus.imemresp_val = 1'b0; bus.imemresp_data = 32'd0;

    // straight-line fetch with 1-cycle memory
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    run_plain(30, 1'b1);

    // back-pressure from reset, then release
    step(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
    run_plain(12, 1'b0);
    run_plain(10, 1'b1);

    // redirect while two requests are in flight (3-cycle memory)
    lat_lo = 3; lat_hi = 3;
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    n = 0;
    while (infl_q.size() != 2 && n < 20) begin run_plain(1, 1'b1); n++; end
    chk("wait_out2", infl_q.size(), 2);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_1000);
    run_plain(20, 1'b1);

    // redirect together with a dequeue and an arriving response; target low bits ignored
    lat_lo = 1; lat_hi = 1;
    n = 0;
    while (!(buf_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc) && n < 20) begin
      run_plain(1, 1'b1); n++;
    end
    chk("wait_simul", {31'd0, buf_q.size() > 0 && mem_q.size() > 0 && mem_q[0].due <= cyc}, 32'd1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2003);
    run_plain(10, 1'b1);

    // back-to-back redirects with 4-cycle memory
    lat_lo = 4; lat_hi = 4;
    run_plain(6, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0040);
    step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0080);
    run_plain(30, 1'b1);

    // reset with three requests outstanding
    n = 0;
    while (infl_q.size() < 3 && n < 30) begin
      step(1'b1, 1'b1, 1'b0, 1'b1, {$urandom_range(255, 0), 2'b00});
      n++;
    end
    chk("wait_out3", infl_q.size(), 3);
    step(1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
    run_plain(20, 1'b1);

    // randomized traffic
    for (int blk = 0; blk < 15; blk++) begin
      lat_lo = 1;
      lat_hi = $urandom_range(4, 1);
      for (int i = 0; i < 200; i++) begin
        step(($urandom_range(499, 0) != 0), ($urandom_range(3, 0) != 0), ($urandom_range(2, 0) != 0),
             ($urandom_range(9, 0) == 0), $urandom() & 32'h0000_FFFF);
      end
    end
    step(1'b1, 1'b1, 1'b1, 1'b0, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
